fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_queue.sv | 119 +++++++++++
 tb/tb_fetch_queue.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the instruction fetch queue.
//   XLEN          : architectural address / instruction width
//   PC_INC        : sequential fetch stride (one 32-bit word)
//   fetch_entry_t : one queued fetch result {pc, inst}
//   align_pc()    : forces a PC onto a word boundary
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- DEPTH-entry circular buffer of fetch_entry_t.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : empties the buffer (wins over push/pop)
//   i_push         : write i_push_data at the tail
//   i_pop          : drop the head entry
//   o_head         : current head entry (meaningful when o_count != 0)
//   o_count        : number of valid entries, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  fetch_entry_t           i_push_data,
    input  logic                   i_pop,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;

    // Storage is cleared on reset so the decode outputs read as zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_push_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (i_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;

    // The credit scheme upstream must never let a push land on a full buffer.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_pop && !i_flush && r_cnt == FULL));

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue -- credit-limited instruction fetcher with an in-order
// response queue feeding decode, and redirect flush handling.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   mem_req_valid/ready/addr  : fetch request channel (word addresses)
//   mem_rsp_valid/data        : in-order responses, always accepted
//   redir_valid/redir_pc      : one-cycle redirect from execute
//   dec_valid/ready/pc/inst   : head of queue towards decode
//   drop_stat                 : discarded-response counter (only when the
//                               FETCH_DROP_STAT_EN macro is defined)
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_inst
`ifdef FETCH_DROP_STAT_EN
    ,
    output logic [31:0]     drop_stat
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_rpc;
    logic [CW-1:0]   r_infl;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   w_cnt;
    logic [CW-1:0]   w_infl_ret;
    logic [CW:0]     w_used;
    logic            w_req_fire;
    logic            w_rsp_fire;
    logic            w_discard;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;

    // Queue slots plus outstanding requests never exceed DEPTH, so every
    // response has a slot waiting for it. Reset gates the request directly
    // so the first request can handshake on the first edge after release.
    assign w_used        = {1'b0, w_cnt} + {1'b0, r_infl};
    assign mem_req_valid = rst && !redir_valid && (w_used < LIMIT);
    assign mem_req_addr  = r_fpc;
    assign w_req_fire    = mem_req_valid && mem_req_ready;

    // A response with nothing outstanding can only belong to a pre-reset
    // request and is ignored.
    assign w_rsp_fire  = mem_rsp_valid && (r_infl != '0);
    assign w_discard   = w_rsp_fire && (redir_valid || r_drop != '0);
    assign w_push      = w_rsp_fire && !w_discard;
    assign w_push_data = '{pc: r_rpc, inst: mem_rsp_data};
    assign w_infl_ret  = r_infl - CW'(w_rsp_fire);

    assign dec_valid = (w_cnt != '0) && !redir_valid;
    assign w_pop     = dec_valid && dec_ready;
    assign dec_pc    = w_head.pc;
    assign dec_inst  = w_head.inst;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_flush     (redir_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc  <= RESET_PC;
            r_rpc  <= RESET_PC;
            r_infl <= '0;
            r_drop <= '0;
        end else begin
            r_infl <= w_infl_ret + CW'(w_req_fire);
            if (redir_valid) begin
                // Everything still outstanding after this cycle's retire
                // belongs to the old path.
                r_fpc  <= align_pc(redir_pc);
                r_rpc  <= align_pc(redir_pc);
                r_drop <= w_infl_ret;
            end else begin
                if (w_req_fire) r_fpc <= r_fpc + PC_INC;
                if (w_push)     r_rpc <= r_rpc + PC_INC;
                if (w_rsp_fire && r_drop != '0) r_drop <= r_drop - CW'(1);
            end
        end
    end

`ifdef FETCH_DROP_STAT_EN
    logic [31:0] r_drop_stat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_drop_stat <= '0;
        else if (w_discard) r_drop_stat <= r_drop_stat + 32'd1;
    end

    assign drop_stat = r_drop_stat;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- randomized bench for fetch_queue with an in-bench
// queue-level reference model, an in-order memory model, and directed
// phases for reset, streaming, backpressure, redirect, corner and wrap.
// Define FETCH_DROP_STAT_EN to also check drop_stat.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_pc, dec_inst;
`ifdef FETCH_DROP_STAT_EN
    logic [31:0] drop_stat;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_pc        (dec_pc),
`ifdef FETCH_DROP_STAT_EN
        .drop_stat     (drop_stat),
`endif
        .dec_inst      (dec_inst)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    ent_t        mq[$];          // model of the decode queue
    logic [31:0] memq[$];        // addresses accepted by memory, not yet answered
    logic [31:0] issue_log[$];
    logic [31:0] pop_log[$];
    int          m_infl, m_drop, rsp_pct;
    logic [31:0] m_fpc, m_rpc, m_expect_pc, m_discards;
    logic        s_req_v;
    logic [31:0] s_req_a, s_dec_pc, s_dec_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] pl(input int i);
        if (i < pop_log.size()) return pop_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl      = 0;
        m_drop      = 0;
        m_fpc       = RPC;
        m_rpc       = RPC;
        m_expect_pc = RPC;
        m_discards  = 0;
    endtask

    // Compare every output against the model, mid-cycle.
    task automatic check_outputs();
        logic ev, dv;
        ev = rst && !redir_valid && (mq.size() + m_infl < DEPTH);
        dv = (mq.size() != 0) && !redir_valid;
        chk("req_valid", mem_req_valid, ev);
        if (ev) chk("req_addr", mem_req_addr, m_fpc);
        chk("dec_valid", dec_valid, dv);
        if (dv) begin
            chk("dec_pc", dec_pc, mq[0].pc);
            chk("dec_inst", dec_inst, mq[0].inst);
        end
        if (!rst) begin
            chk("rst_dec_pc", dec_pc, 32'h0);
            chk("rst_dec_inst", dec_inst, 32'h0);
        end
`ifdef FETCH_DROP_STAT_EN
        chk("drop_stat", drop_stat, m_discards);
`endif
    endtask

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_update();
        logic req_fire, rsp, pop;
        if (!rst) begin
            model_reset();
            return;
        end
        req_fire = (mq.size() + m_infl < DEPTH) && !redir_valid && mem_req_ready;
        rsp      = mem_rsp_valid && (m_infl > 0);
        pop      = (mq.size() != 0) && !redir_valid && dec_ready;
        if (pop) begin
            void'(mq.pop_front());
            pop_log.push_back(s_dec_pc);
            // Decode sees a consecutive stream from the last redirect target,
            // each word being exactly what memory holds at that PC.
            chk("stream_pc", s_dec_pc, m_expect_pc);
            chk("stream_inst", s_dec_inst, mem_word(m_expect_pc));
            m_expect_pc += 32'd4;
        end
        if (redir_valid) begin
            if (rsp) begin
                m_infl--;
                m_discards++;
            end
            mq.delete();
            m_drop      = m_infl;
            m_fpc       = redir_pc & ~32'd3;
            m_rpc       = m_fpc;
            m_expect_pc = m_fpc;
        end else begin
            if (req_fire) begin
                m_fpc += 32'd4;
                m_infl++;
            end
            if (rsp) begin
                m_infl--;
                if (m_drop > 0) begin
                    m_drop--;
                    m_discards++;
                end else begin
                    mq.push_back('{pc: m_rpc, inst: mem_rsp_data});
                    m_rpc += 32'd4;
                end
            end
        end
    endtask

    task automatic mem_update();
        if (!rst) begin
            memq.delete();
        end else begin
            if (mem_rsp_valid && memq.size() != 0) void'(memq.pop_front());
            if (s_req_v && mem_req_ready) begin
                memq.push_back(s_req_a);
                issue_log.push_back(s_req_a);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        s_req_v    = mem_req_valid;
        s_req_a    = mem_req_addr;
        s_dec_pc   = dec_pc;
        s_dec_inst = dec_inst;
        @(posedge clk);
        model_update();
        mem_update();
        #1;
        if (rst && memq.size() != 0 && int'($urandom_range(99)) < rsp_pct) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(memq[0]);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        redir_valid = 1'b1;
        redir_pc    = pc;
        step();
        redir_valid = 1'b0;
    endtask

    initial begin
        int ps, pm, is;
        logic [31:0] d0;
        rst = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        redir_valid   = 1'b0;
        redir_pc      = '0;
        dec_ready     = 1'b0;
        rsp_pct       = 0;
        model_reset();
        #2;
        chk("reset_req_valid", mem_req_valid, 1'b0);
        chk("reset_dec_valid", dec_valid, 1'b0);
        chk("reset_dec_pc", dec_pc, 32'h0);
        chk("reset_dec_inst", dec_inst, 32'h0);
        repeat (2) step();

        // Reset release: four sequential fetches then the credit runs out.
        rst = 1'b1;
        mem_req_ready = 1'b1;
        repeat (4) step();
        chk("rst_issue_cnt", issue_log.size(), 4);
        chk("rst_addr0", issue_log[0], 32'h100);
        chk("rst_addr1", issue_log[1], 32'h104);
        chk("rst_addr2", issue_log[2], 32'h108);
        chk("rst_addr3", issue_log[3], 32'h10C);
        #1 chk("rst_credit_stop", mem_req_valid, 1'b0);

        // Streaming with a one-cycle memory.
        rsp_pct = 100;
        dec_ready = 1'b1;
        repeat (8) step();
        chk("first_pop", pl(0), 32'h100);
        redirect(32'h0);
        ps = pop_log.size();
        repeat (10) step();
        pm = pop_log.size();
        repeat (10) step();
        chk("stream_rate", pop_log.size() - pm, 10);
        chk("stream_pc0", pl(ps), 32'h0);
        chk("stream_pc1", pl(ps + 1), 32'h4);
        chk("stream_pc2", pl(ps + 2), 32'h8);

        // Backpressure: exactly DEPTH entries, then resume.
        dec_ready = 1'b0;
        redirect(32'h400);
        is = issue_log.size();
        repeat (12) step();
        chk("bp_issued", issue_log.size() - is, 4);
        #1;
        chk("bp_dec_valid", dec_valid, 1'b1);
        chk("bp_dec_pc", dec_pc, 32'h400);
        chk("bp_no_req", mem_req_valid, 1'b0);
        dec_ready = 1'b1;
        ps = pop_log.size();
        repeat (3) step();
        chk("bp_resume", pl(ps), 32'h400);

        // Redirect with three requests in flight.
        mem_req_ready = 1'b0;
        repeat (10) step();
        rsp_pct = 0;
        mem_req_ready = 1'b1;
        is = issue_log.size();
        repeat (3) step();
        mem_req_ready = 1'b0;
        chk("rd_issued", issue_log.size() - is, 3);
        rsp_pct = 100;
        d0 = m_discards;
        redirect(32'h200);
        repeat (3) step();
        chk("rd_discards", m_discards - d0, 3);
        #1;
        chk("rd_dec_empty", dec_valid, 1'b0);
        chk("rd_req_valid", mem_req_valid, 1'b1);
        chk("rd_req_addr", mem_req_addr, 32'h200);
        mem_req_ready = 1'b1;
        ps = pop_log.size();
        repeat (6) step();
        chk("rd_first_pc", pl(ps), 32'h200);

        // Redirect coincident with response and pop, then a second redirect.
        repeat (12) step();
        redirect(32'h250);
        redirect(32'h300);
        ps = pop_log.size();
        repeat (12) step();
        chk("corner_pc0", pl(ps), 32'h300);
        chk("corner_pc1", pl(ps + 1), 32'h304);

        // Address wrap, with an unaligned target that must be masked.
        redirect(32'hFFFF_FFFF);
        ps = pop_log.size();
        repeat (10) step();
        chk("wrap_pc0", pl(ps), 32'hFFFF_FFFC);
        chk("wrap_pc1", pl(ps + 1), 32'h0);

        // Asynchronous reset in the middle of streaming.
        repeat (5) step();
        rst = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        chk("mid_rst_req", mem_req_valid, 1'b0);
        chk("mid_rst_dec", dec_valid, 1'b0);
        chk("mid_rst_pc", dec_pc, 32'h0);
        chk("mid_rst_inst", dec_inst, 32'h0);
        model_reset();
        memq.delete();
        repeat (2) step();
        rst = 1'b1;
        ps = pop_log.size();
        repeat (6) step();
        chk("mid_rst_first", pl(ps), RPC);

        // Random traffic, including back-to-back redirects.
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rsp_pct = int'($urandom_range(100, 20));
            mem_req_ready = ($urandom_range(3) != 0);
            dec_ready     = ($urandom_range(2) != 0);
            redir_valid   = ($urandom_range(19) == 0);
            redir_pc      = $urandom;
            step();
        end
        redir_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
